// File: rtl/scm_stream_pkg.sv
// Shared types and helpers for the SCM read streamer.
// Optional build macro used by the top: SCM_STREAM_STRIDE_EN.
package scm_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  localparam int FIFO_DEPTH = 2;

  // Address after one issue, wrapping modulo 2**aw.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [31:0] inc,
                                            input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (addr + inc) & mask;
  endfunction

endpackage

// File: rtl/scm_stream_fifo.sv
// Two-entry register FIFO carrying a data word plus its last-beat flag.
module scm_stream_fifo
  import scm_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_push_last,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem  [FIFO_DEPTH];
  logic                  r_last [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: payload storage is left unreset; o_data/o_last are masked by o_valid,
  // so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr]  <= i_push_data;
      r_last[r_wr_ptr] <= i_push_last;
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_last  = o_valid & r_last[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/scm_read_streamer.sv
// Burst reader for the 1R1W SCM: issues sequential reads, absorbs the one-cycle
// read latency and emits a valid/ready stream. Build option: SCM_STREAM_STRIDE_EN.
module scm_read_streamer
  import scm_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
`ifdef SCM_STREAM_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rf_ren_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_issue_cnt;
  logic [ADDR_WIDTH:0]   r_beat_cnt;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_done;

  logic                  w_pop;
  logic                  w_ren;
  logic                  w_accept;
  logic                  w_last_hs;
  logic [1:0]            w_fifo_count;
  logic [2:0]            w_occ;
  logic [ADDR_WIDTH-1:0] w_inc;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

`ifdef SCM_STREAM_STRIDE_EN
  assign w_inc = stride_i;
`else
  assign w_inc = ADDR_WIDTH'(1);
`endif

  assign w_pop      = m_valid_o & m_ready_i;
  assign w_accept   = (r_state == IDLE) && start_i && (len_i != '0);
  assign w_last_hs  = w_pop && (r_beat_cnt == CNT_ONE);
  assign w_addr_nxt = ADDR_WIDTH'(next_addr(32'(r_addr), 32'(w_inc), ADDR_WIDTH));

  // Slots already claimed after this cycle's pop: buffered words plus the read in flight.
  assign w_occ = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_ren = (r_state == ISSUE) && (r_issue_cnt != '0) && (w_occ < 3'(FIFO_DEPTH));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (w_ren && (r_issue_cnt == CNT_ONE)) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_issue_cnt     <= '0;
      r_beat_cnt      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_ren;
      r_inflight_last <= w_ren && (r_issue_cnt == CNT_ONE);
      r_done          <= ((r_state == IDLE) && start_i && (len_i == '0)) ||
                         ((r_state == DRAIN) && w_last_hs);
      if (w_accept) begin
        r_addr      <= base_addr_i;
        r_issue_cnt <= len_i;
        r_beat_cnt  <= len_i;
      end else begin
        if (w_ren) begin
          r_addr      <= w_addr_nxt;
          r_issue_cnt <= r_issue_cnt - CNT_ONE;
        end
        if (w_pop) r_beat_cnt <= r_beat_cnt - CNT_ONE;
      end
    end
  end

  scm_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (rf_rdata_i),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_valid     (m_valid_o),
    .o_data      (m_data_o),
    .o_last      (m_last_o),
    .o_count     (w_fifo_count)
  );

  assign busy_o     = (r_state != IDLE);
  assign done_o     = r_done;
  assign rf_ren_o   = w_ren;
  assign rf_raddr_o = (r_state == ISSUE) ? r_addr : '0;

endmodule

// File: tb/tb_scm_read_streamer.sv
// Directed bench for scm_read_streamer with an SCM model and a beat scoreboard.
// Define SCM_STREAM_STRIDE_EN to also exercise the stride build.
module tb_scm_read_streamer;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   len_i;
`ifdef SCM_STREAM_STRIDE_EN
  logic [AW-1:0] stride_i;
`endif
  logic          busy_o;
  logic          done_o;
  logic          rf_ren_o;
  logic [AW-1:0] rf_raddr_o;
  logic [DW-1:0] rf_rdata_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;

  logic [DW-1:0] mem [NW];

  always #5 clk = ~clk;

  scm_read_streamer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
`ifdef SCM_STREAM_STRIDE_EN
    .stride_i    (stride_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rf_ren_o    (rf_ren_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o)
  );

  // SCM read port: data valid the cycle after the edge that samples ren.
  always @(posedge clk)
    rf_rdata_i <= rf_ren_o ? mem[rf_raddr_o] : 32'hBADB_AD00;

  int            checks = 0;
  int            failures = 0;
  beat_t         exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            cyc = 0;
  int            start_cyc, outstanding;
  int            first_ren, last_ren, ren_count, first_valid;
  int            last_hs_cyc, hs_count, done_cyc, done_seen;
  logic          busy_at_done;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic step();
    logic  pop;
    beat_t b;
    @(negedge clk);
    cyc++;
    pop = m_valid_o & m_ready_i;
    if (rf_ren_o) begin
      check("ren_occupancy", 64'((outstanding - int'(pop)) < 2), 64'd1);
      if (addr_q.size() == 0) check("ren_unexpected", 64'(rf_ren_o), 64'd0);
      else check("rf_raddr", 64'(rf_raddr_o), 64'(addr_q.pop_front()));
      if (first_ren < 0) first_ren = cyc;
      last_ren = cyc;
      ren_count++;
    end
    if (prev_stall) begin
      check("hold_valid", 64'(m_valid_o), 64'd1);
      check("hold_data", 64'(m_data_o), 64'(prev_data));
      check("hold_last", 64'(m_last_o), 64'(prev_last));
    end
    if (m_valid_o && first_valid < 0) first_valid = cyc;
    if (pop) begin
      if (exp_q.size() == 0) check("beat_unexpected", 64'(m_valid_o), 64'd0);
      else begin
        b = exp_q.pop_front();
        check("beat_data", 64'(m_data_o), 64'(b.data));
        check("beat_last", 64'(m_last_o), 64'(b.last));
        if (b.last) last_hs_cyc = cyc;
      end
      hs_count++;
    end
    if (done_o) begin
      done_seen++;
      done_cyc = cyc;
      busy_at_done = busy_o;
    end
    outstanding += int'(rf_ren_o) - int'(pop);
    prev_stall = m_valid_o & ~m_ready_i;
    prev_data  = m_data_o;
    prev_last  = m_last_o;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [AW-1:0] base, input int len, input logic [AW-1:0] inc);
    logic [AW-1:0] a;
    a = base;
    for (int k = 0; k < len; k++) begin
      addr_q.push_back(a);
      exp_q.push_back('{mem[a], (k == len - 1)});
      a = a + inc;
    end
    first_ren = -1; last_ren = -1; ren_count = 0; first_valid = -1;
    last_hs_cyc = -1; hs_count = 0; done_seen = 0; done_cyc = -1;
    start_i = 1'b1;
    base_addr_i = base;
    len_i = (AW + 1)'(len);
`ifdef SCM_STREAM_STRIDE_EN
    stride_i = inc;
`endif
    step();
    start_cyc = cyc;
    start_i = 1'b0;
  endtask

  // mode 0: ready held high; 1: 1,0,0,1,0,1 pattern; 2: random ready.
  task automatic run_burst(input string tag, input int mode, input int budget);
    int n;
    n = 0;
    while (done_seen == 0 && n < budget) begin
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = pat[n % 6];
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
      step();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    check({tag, "_done_gap"}, 64'(done_cyc - last_hs_cyc), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_reads_left"}, 64'(addr_q.size()), 64'd0);
    check({tag, "_done_width"}, 64'(done_o), 64'd0);
    check({tag, "_idle_valid"}, 64'(m_valid_o), 64'd0);
    check({tag, "_idle_data"}, 64'(m_data_o), 64'd0);
    check({tag, "_idle_raddr"}, 64'(rf_raddr_o), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 32'h5A00_0000 | (32'(i) << 8) | (32'(i) ^ 32'h3C);
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b0;
`ifdef SCM_STREAM_STRIDE_EN
    stride_i = '0;
`endif
    outstanding = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ren", 64'(rf_ren_o), 64'd0);
    check("rst_raddr", 64'(rf_raddr_o), 64'd0);
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_last", 64'(m_last_o), 64'd0);
    check("rst_data", 64'(m_data_o), 64'd0);
    rst = 1'b0;
    m_ready_i = 1'b1;
    step();

    // Basic burst, ready held high: latency, back-to-back reads, single done pulse.
    start_burst(5'd3, 4, 5'd1);
    check("b1_busy", 64'(busy_o), 64'd1);
    run_burst("b1", 0, 40);
    check("b1_latency", 64'(first_valid - start_cyc), 64'd3);
    check("b1_first_ren", 64'(first_ren - start_cyc), 64'd1);
    check("b1_ren_span", 64'(last_ren - first_ren), 64'd3);
    check("b1_ren_count", 64'(ren_count), 64'd4);

    // Address wrap through 0 with random backpressure.
    start_burst(5'd30, 4, 5'd1);
    run_burst("wrap", 2, 200);

    // Toggling backpressure.
    start_burst(5'd12, 5, 5'd1);
    run_burst("bp", 1, 200);

    // Zero-length request: one done pulse, no reads, never busy.
    start_burst(5'd7, 0, 5'd1);
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd0);
    step();
    check("len0_done_width", 64'(done_o), 64'd0);
    check("len0_busy2", 64'(busy_o), 64'd0);
    check("len0_done_seen", 64'(done_seen), 64'd1);

    // Start while busy is ignored.
    start_burst(5'd10, 3, 5'd1);
    step();
    start_i = 1'b1; base_addr_i = 5'd20; len_i = 6'd5;
    step();
    start_i = 1'b0;
    check("busy_ignore", 64'(busy_o), 64'd1);
    run_burst("ignore", 0, 40);
    step();
    check("ignore_no_reads", 64'(ren_count), 64'd3);

    // Reset after two of six beats, then a fresh burst.
    start_burst(5'd0, 6, 5'd1);
    for (int n = 0; n < 20 && hs_count < 2; n++) step();
    check("rst_mid_beats", 64'(hs_count), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete(); addr_q.delete(); outstanding = 0; prev_stall = 1'b0;
    check("rstm_valid", 64'(m_valid_o), 64'd0);
    check("rstm_busy", 64'(busy_o), 64'd0);
    check("rstm_ren", 64'(rf_ren_o), 64'd0);
    check("rstm_done", 64'(done_o), 64'd0);
    done_seen = 0;
    repeat (3) step();
    check("rstm_no_done", 64'(done_seen), 64'd0);
    start_burst(5'd0, 2, 5'd1);
    run_burst("after_rst", 0, 40);

    // Whole array starting mid-range.
    start_burst(5'd5, NW, 5'd1);
    run_burst("full", 2, 400);
    check("full_reads", 64'(ren_count), 64'(NW));

`ifdef SCM_STREAM_STRIDE_EN
    start_burst(5'd1, 5, 5'd8);
    run_burst("stride", 0, 40);
    start_burst(5'd9, 3, 5'd0);
    run_burst("stride0", 1, 60);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scm_read_streamer.md
Name: scm_read_streamer

Overview:
- Read-side initiator for the latch-based 1R1W byte-enable register file (SCM).
- On a start command, issues a burst of sequential reads (base address, word count) on the SCM read port and absorbs the SCM's one-cycle read latency.
- Presents the words as a valid/ready stream with last-beat marking and full throughput under backpressure.
- Sits between the SCM and a cluster-side consumer (DMA or accelerator input).

Parameters:
- ADDR_WIDTH, 5, SCM address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, SCM and stream data width; a multiple of 8.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2 in this revision.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  burst request; accepted only when busy_o=0
- base_addr_i  in  ADDR_WIDTH  first word address, sampled with start_i
- len_i  in  ADDR_WIDTH+1  word count, 0..NUM_WORDS, sampled with start_i
- stride_i  in  ADDR_WIDTH  address increment; present only with SCM_STREAM_STRIDE_EN
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse when the burst completes
- rf_ren_o  out  1  to SCM ReadEnable
- rf_raddr_o  out  ADDR_WIDTH  to SCM ReadAddr
- rf_rdata_i  in  DATA_WIDTH  from SCM ReadData; valid the cycle after the edge that samples ren
- m_valid_o  out  1  stream valid
- m_ready_i  in  1  stream ready
- m_data_o  out  DATA_WIDTH  stream data
- m_last_o  out  1  final word of the burst

Behaviour:
- Reset (sync, rst=1 at edge): FSM=IDLE, counters=0, FIFO empty, in-flight flag=0.
- Outputs in reset and IDLE: busy_o=0, done_o=0, rf_ren_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, rf_raddr_o=0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE: on start_i with len_i>0. Latch addr=base_addr_i, issue_cnt=len_i, beat_cnt=len_i.
- IDLE with start_i and len_i=0: stay IDLE; done_o pulses the next cycle; no SCM reads.
- ISSUE: rf_ren_o=1 when issue_cnt>0 AND (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = m_valid_o & m_ready_i.
- On each issue: addr += 1 (or stride_i), modulo 2**ADDR_WIDTH (wrap, no error); issue_cnt -= 1; inflight <= 1.
- Cycle after an issue: rf_rdata_i is pushed into the FIFO and inflight clears, unless a new issue occurs.
- rf_raddr_o = addr (combinational from register); rf_ren_o=0 otherwise.
- ISSUE -> DRAIN: when issue_cnt reaches 0.
- DRAIN -> IDLE: on the handshake with beat_cnt=1. done_o=1 in the following cycle; busy_o=0 in that same cycle.
- busy_o=1 in ISSUE and DRAIN. start_i is ignored while busy.
- Stream rules:
  - m_valid_o, m_data_o and m_last_o come from the FIFO head (registered) and stay stable until the handshake.
  - m_last_o=1 exactly when the head word is the final beat (beat_cnt=1).
  - beat_cnt decrements on each handshake.
- Latency: start edge E0 -> rf_ren_o=1 in cycle E0..E1 -> SCM samples at E1 -> FIFO push at E2 -> m_valid_o=1 after E2 (3 cycles).
- Throughput: 1 word/cycle with m_ready_i held at 1.
- Backpressure: never drops or duplicates words. When ready is low, issue stalls once FIFO plus in-flight reaches 2.
- Simultaneous push and pop with a full FIFO is legal; count is unchanged.
- Reset mid-burst: FIFO flushed, any in-flight read discarded, no done_o pulse.
- len_i=NUM_WORDS: reads every word once, wrapping through address 0 when base>0.

Optional Feature:
- Macro: SCM_STREAM_STRIDE_EN.
- Defined: stride_i port present and addr += stride_i per issue, modulo 2**ADDR_WIDTH. stride_i=0 rereads the same word len times.
- Undefined: no stride_i port; increment is fixed at 1.

Decomposition:
- Shared package scm_stream_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN};
  - localparam FIFO_DEPTH=2;
  - the function computing the next address with wrap.
- Natural sub-module: scm_stream_fifo, a 2-entry register FIFO with push/pop, count, and data+last payload.

Test Plan:
- base=3, len=4, ready=1 -> SCM reads addr 3,4,5,6 on consecutive cycles; m_valid_o first high 3 cycles after start; data equals mem[3..6]; m_last_o only on mem[6]; done_o pulse 1 cycle after the last handshake.
- base=30, len=4 (ADDR_WIDTH=5) -> reads 30,31,0,1 in that order; no error.
- len=5 with ready toggling 1,0,0,1,0,1... -> the full sequence arrives in order with no loss or duplication; rf_ren_o low whenever FIFO+in-flight=2; m_data_o stable while valid&!ready.
- len=0 start -> no rf_ren_o; done_o high exactly 1 cycle; busy_o stays 0. start during busy -> ignored; current burst unaffected.
- rst=1 mid-burst after 2 of 6 beats -> next cycle m_valid_o=0, busy_o=0, rf_ren_o=0, no done_o; a new burst base=0, len=2 then completes correctly.
- SCM_STREAM_STRIDE_EN, base=1, stride=8, len=5 -> reads 1,9,17,25,1.
